// File: rtl/n64_vinfo_gen_pkg.sv
// Shared definitions for the N64 video-info stage: sync nibble bit positions,
// demux control word layout and reset defaults.
package n64_vinfo_gen_pkg;

    // Sync nibble carried on data bus bits [3:0] during the nDSYNC=0 cycle
    localparam int SYNC_VSYNC = 3;
    localparam int SYNC_CLAMP = 2;
    localparam int SYNC_HSYNC = 1;
    localparam int SYNC_CSYNC = 0;

    localparam logic [3:0] SYNC_RST = 4'hF;

    // Demux control word: {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}
    localparam int DMX_W       = 5;
    localparam int DMX_N15BIT  = 0;
    localparam int DMX_NDEBLUR = 1;
    localparam int DMX_VMODE   = 2;
    localparam int DMX_CNT_LSB = 3;

    localparam logic [1:0] DATA_CNT_RST = 2'b00;
    localparam logic       VMODE_RST    = 1'b0;
    localparam logic       NDEBLUR_RST  = 1'b1;
    localparam logic       N15BIT_RST   = 1'b1;
    localparam logic       CFG_SYNC_RST = 1'b1;

    function automatic logic [DMX_W-1:0] pack_demux(
        input logic [1:0] data_cnt,
        input logic       vmode,
        input logic       ndo_deblur,
        input logic       n15bit_mode
    );
        logic [DMX_W-1:0] w;
        w                          = '0;
        w[DMX_CNT_LSB +: 2]        = data_cnt;
        w[DMX_VMODE]               = vmode;
        w[DMX_NDEBLUR]             = ndo_deblur;
        w[DMX_N15BIT]              = n15bit_mode;
        return w;
    endfunction

endpackage

// File: rtl/n64_sync_edge.sv
// Holds the last sync nibble and flags falling nHSYNC/nVSYNC on sync cycles.
// Latency: strobes are combinational in the nDSYNC=0 cycle; no backpressure.
// Backpressure: none, the video bus free-runs on VCLK.
module n64_sync_edge
    import n64_vinfo_gen_pkg::*;
(
    input  logic       VCLK,
    input  logic       nRST,
    input  logic       nDSYNC,
    input  logic [3:0] Sync_i,
    output logic       negedge_hsync,
    output logic       negedge_vsync
);

    logic [3:0] sync_prev;

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            sync_prev <= SYNC_RST;
        end else if (!nDSYNC) begin
            sync_prev <= Sync_i;
        end
    end

    // Data cycles carry pixel bytes, so edges are only judged on sync cycles
    assign negedge_hsync = !nDSYNC && sync_prev[SYNC_HSYNC] && !Sync_i[SYNC_HSYNC];
    assign negedge_vsync = !nDSYNC && sync_prev[SYNC_VSYNC] && !Sync_i[SYNC_VSYNC];

    logic unused_sync_bits;
    assign unused_sync_bits = ^{sync_prev[SYNC_CLAMP], sync_prev[SYNC_CSYNC]};

endmodule

// File: rtl/n64_vinfo_gen.sv
// Builds the demux control word, NTSC/PAL and 480i detection; VINFO_HYST_EN adds 2-field hysteresis.
// Latency: all outputs registered; mode/config changes appear the cycle after the nVSYNC-fall sync cycle.
// Backpressure: none, follows the free-running N64 video bus.
module n64_vinfo_gen
    import n64_vinfo_gen_pkg::*;
#(
    parameter int                   LINECNT_W   = 10,
    parameter logic [LINECNT_W-1:0] PAL_LINE_TH = 10'd290
) (
    input  logic             VCLK,
    input  logic             nRST,
    input  logic             nDSYNC,
    input  logic [3:0]       Sync_i,
    input  logic             nDeBlur_i,
    input  logic             n15bit_i,
    output logic [DMX_W-1:0] demuxparams_o,
    output logic             n64_480i_o,
    output logic             field_o
);

    logic                 negedge_hsync;
    logic                 negedge_vsync;
    logic [1:0]           deblur_sync;
    logic [1:0]           n15bit_sync;
    logic [LINECNT_W-1:0] linecnt;
    logic [1:0]           data_cnt;
    logic                 vmode;
    logic                 ndo_deblur;
    logic                 n15bit_mode;
    logic                 pal_eval;
    logic                 i480_eval;
    logic                 vmode_next;
    logic                 i480_next;

    n64_sync_edge u_sync_edge (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .nDSYNC        (nDSYNC),
        .Sync_i        (Sync_i),
        .negedge_hsync (negedge_hsync),
        .negedge_vsync (negedge_vsync)
    );

    // User switches are asynchronous to VCLK
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            deblur_sync <= {2{CFG_SYNC_RST}};
            n15bit_sync <= {2{CFG_SYNC_RST}};
        end else begin
            deblur_sync <= {deblur_sync[0], nDeBlur_i};
            n15bit_sync <= {n15bit_sync[0], n15bit_i};
        end
    end

    assign pal_eval  = (linecnt >= PAL_LINE_TH);
    assign i480_eval = (Sync_i[SYNC_HSYNC] != field_o);

`ifdef VINFO_HYST_EN
    logic vmode_pend;
    logic i480_pend;

    // An evaluation is only adopted once it repeats on the following field
    assign vmode_next = (pal_eval  == vmode_pend) ? pal_eval  : vmode;
    assign i480_next  = (i480_eval == i480_pend)  ? i480_eval : n64_480i_o;

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            vmode_pend <= 1'b0;
            i480_pend  <= 1'b0;
        end else if (negedge_vsync) begin
            vmode_pend <= pal_eval;
            i480_pend  <= i480_eval;
        end
    end
`else
    assign vmode_next = pal_eval;
    assign i480_next  = i480_eval;
`endif

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            data_cnt    <= DATA_CNT_RST;
            linecnt     <= '0;
            vmode       <= VMODE_RST;
            ndo_deblur  <= NDEBLUR_RST;
            n15bit_mode <= N15BIT_RST;
            n64_480i_o  <= 1'b0;
            field_o     <= 1'b0;
        end else begin
            data_cnt <= !nDSYNC ? 2'b01 : data_cnt + 2'd1;

            // Frame boundary: the clear wins over a coincident nHSYNC fall
            if (negedge_vsync) begin
                linecnt     <= '0;
                vmode       <= vmode_next;
                n64_480i_o  <= i480_next;
                field_o     <= Sync_i[SYNC_HSYNC];
                n15bit_mode <= n15bit_sync[1];
                ndo_deblur  <= deblur_sync[1] | i480_next;
            end else if (negedge_hsync && (linecnt != '1)) begin
                linecnt <= linecnt + LINECNT_W'(1);
            end
        end
    end

    assign demuxparams_o = pack_demux(data_cnt, vmode, ndo_deblur, n15bit_mode);

endmodule

// File: tb/tb_n64_vinfo_gen.sv
// Randomised bench for n64_vinfo_gen against a field-level reference model.
module tb_n64_vinfo_gen;

    logic       VCLK = 1'b0;
    logic       nRST;
    logic       nDSYNC;
    logic [3:0] Sync_i;
    logic       nDeBlur_i;
    logic       n15bit_i;
    logic [4:0] demuxparams_o;
    logic       n64_480i_o;
    logic       field_o;

    n64_vinfo_gen dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .nDSYNC        (nDSYNC),
        .Sync_i        (Sync_i),
        .nDeBlur_i     (nDeBlur_i),
        .n15bit_i      (n15bit_i),
        .demuxparams_o (demuxparams_o),
        .n64_480i_o    (n64_480i_o),
        .field_o       (field_o)
    );

    always #5 VCLK = ~VCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, advanced once per sync word
    logic [3:0] m_prev;
    int         m_lines;
    bit         m_vmode, m_deblur, m_n15, m_i480, m_field;
    bit         m_db_q0, m_db_q1, m_n15_q0, m_n15_q1;
    bit         hist_pal[$];
    bit         hist_i[$];

    logic [4:0] act_vec;
    assign act_vec = {demuxparams_o[2:0], n64_480i_o, field_o};

    function automatic logic [4:0] exp_vec();
        return {m_vmode, m_deblur, m_n15, m_i480, m_field};
    endfunction

    task automatic model_reset();
        m_prev  = 4'hF;
        m_lines = 0;
        m_vmode = 0; m_deblur = 1; m_n15 = 1; m_i480 = 0; m_field = 0;
        m_db_q0 = 1; m_db_q1 = 1; m_n15_q0 = 1; m_n15_q1 = 1;
        hist_pal.delete();
        hist_i.delete();
    endtask

    task automatic model_word(input logic [3:0] w);
        bit hf, vf, pal, alt;
        hf = m_prev[1] && !w[1];
        vf = m_prev[3] && !w[3];
        if (vf) begin
            pal = (m_lines >= 290);
            alt = (w[1] != m_field);
`ifdef VINFO_HYST_EN
            if (hist_pal.size() > 0 && hist_pal[$] == pal) m_vmode = pal;
            if (hist_i.size() > 0 && hist_i[$] == alt) m_i480 = alt;
            hist_pal.push_back(pal);
            hist_i.push_back(alt);
`else
            m_vmode = pal;
            m_i480  = alt;
`endif
            m_field  = w[1];
            m_n15    = m_n15_q1;
            m_deblur = m_db_q1 | m_i480;
            m_lines  = 0;
        end else if (hf && m_lines < 1023) begin
            m_lines++;
        end
        m_prev = w;
    endtask

    // One VCLK cycle; the switches pass two register stages before use
    task automatic drive(input bit nd, input logic [3:0] s);
        nDSYNC = nd;
        Sync_i = s;
        @(posedge VCLK);
        #1;
        if (!nd) model_word(s);
        m_db_q1  = m_db_q0;  m_db_q0  = nDeBlur_i;
        m_n15_q1 = m_n15_q0; m_n15_q0 = n15bit_i;
    endtask

    task automatic send_word(input bit v, input bit h);
        drive(1'b0, {v, 1'($urandom), h, 1'($urandom)});
        drive(1'b1, 4'($urandom));
    endtask

    task automatic send_lines(input int n);
        repeat (n) begin
            send_word(1'b1, 1'b1);
            send_word(1'b1, 1'b0);
        end
    endtask

    task automatic send_field(input int lines, input bit h);
        send_lines(lines);
        send_word(1'b0, h);
    endtask

    task automatic test_reset();
        nRST = 1'b0; nDSYNC = 1'b1; Sync_i = 4'hF; nDeBlur_i = 1'b1; n15bit_i = 1'b1;
        model_reset();
        #23;
        n_tests++;
        if (demuxparams_o !== 5'b00011) begin
            n_fail++; $display("FAIL reset_demux: got %b expected 00011", demuxparams_o);
        end
        n_tests++;
        if (n64_480i_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_480i: got %b expected 0", n64_480i_o);
        end
        n_tests++;
        if (field_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_field: got %b expected 0", field_o);
        end
        @(posedge VCLK); #1;
        nRST = 1'b1;
        drive(1'b1, 4'hF);
        n_tests++;
        if (demuxparams_o[2:0] !== 3'b011) begin
            n_fail++; $display("FAIL reset_release: got %b expected 011", demuxparams_o[2:0]);
        end
    endtask

    task automatic test_data_cnt();
        bit         nd_tab[6] = '{0, 1, 1, 1, 0, 1};
        logic [1:0] dc_tab[6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            drive(nd_tab[i], 4'hF);
            n_tests++;
            if (demuxparams_o[4:3] !== dc_tab[i]) begin
                n_fail++;
                $display("FAIL data_cnt step %0d: got %b expected %b", i, demuxparams_o[4:3], dc_tab[i]);
            end
        end
    endtask

    task automatic test_vmode();
        for (int i = 0; i < 6; i++) begin
            send_field((i < 3) ? 263 : 313, 1'b0);
            n_tests++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL vmode field %0d: got %b expected %b", i, act_vec, exp_vec());
            end
        end
`ifndef VINFO_HYST_EN
        n_tests++;
        if (demuxparams_o[2] !== 1'b1) begin
            n_fail++; $display("FAIL vmode_pal: got %b expected 1", demuxparams_o[2]);
        end
`endif
    endtask

    task automatic test_480i();
        bit h_tab[7] = '{1, 0, 1, 0, 1, 1, 1};
        nDeBlur_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_field(int'($urandom_range(255, 270)), h_tab[i]);
            n_tests++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL 480i field %0d: got %b expected %b", i, act_vec, exp_vec());
            end
            if (i == 4) begin
                n_tests++;
                if (n64_480i_o !== 1'b1 || demuxparams_o[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL 480i_forced_deblur: got %b%b expected 11", n64_480i_o, demuxparams_o[1]);
                end
            end
        end
        n_tests++;
        if (n64_480i_o !== 1'b0 || demuxparams_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL 480i_cleared: got %b%b expected 00", n64_480i_o, demuxparams_o[1]);
        end
    endtask

    task automatic test_config();
        nDeBlur_i = 1'b1;
        send_field(263, 1'b0);
        send_lines(10);
        n15bit_i = 1'b0;
        send_lines(10);
        n_tests++;
        if (demuxparams_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL cfg_frozen: got %b expected 1", demuxparams_o[0]);
        end
        send_word(1'b0, 1'b0);
        n_tests++;
        if (act_vec !== exp_vec() || demuxparams_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL cfg_boundary: got %b expected %b", act_vec, exp_vec());
        end
        // A change one cycle before the boundary has not cleared the synchroniser yet
        send_lines(5);
        n15bit_i = 1'b1;
        send_word(1'b0, 1'b0);
        n_tests++;
        if (act_vec !== exp_vec() || demuxparams_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL cfg_late: got %b expected %b", act_vec, exp_vec());
        end
        send_field(20, 1'b0);
        n_tests++;
        if (act_vec !== exp_vec() || demuxparams_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL cfg_next: got %b expected %b", act_vec, exp_vec());
        end
    endtask

    task automatic test_saturate();
        send_field(263, 1'b0);
        send_field(263, 1'b0);
        send_lines(1100);
        n_tests++;
        if (act_vec !== exp_vec() || demuxparams_o[2] !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: got %b expected %b", act_vec, exp_vec());
        end
        send_word(1'b0, 1'b0);
        n_tests++;
        if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL sat_eval: got %b expected %b", act_vec, exp_vec());
        end
    endtask

    task automatic test_hyst_glitch();
        int l_tab[5] = '{263, 263, 313, 263, 263};
        for (int i = 0; i < 5; i++) begin
            send_field(l_tab[i], 1'b0);
            n_tests++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch field %0d: got %b expected %b", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            nDeBlur_i = 1'($urandom);
            n15bit_i  = 1'($urandom);
            send_field(int'($urandom_range(200, 340)), 1'($urandom));
            n_tests++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random field %0d: got %b expected %b", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        n15bit_i = 1'b0;
        send_field(313, 1'b1);
        send_field(313, 1'b0);
        send_lines(3);
        nDSYNC = 1'b1;
        @(posedge VCLK);
        #3 nRST = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (demuxparams_o !== 5'b00011 || n64_480i_o !== 1'b0 || field_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b %b %b expected 00011 0 0", demuxparams_o, n64_480i_o, field_o);
        end
        @(posedge VCLK); #1;
        nRST = 1'b1;
        send_field(263, 1'b1);
        n_tests++;
        if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_first_vsync: got %b expected %b", act_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_data_cnt();
        test_vmode();
        test_480i();
        test_config();
        test_saturate();
        test_hyst_glitch();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/n64_vinfo_gen.md
Name: n64_vinfo_gen

Overview:
- Upstream neighbour of the video demux stage; sits directly on the N64 VCLK/nDSYNC/data bus.
- Generates the 5-bit demux control word consumed by the demux: {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}.
- Tracks the pixel-phase counter, measures lines per field for NTSC/PAL, detects 480i vs 240p, and gates user config so it only changes on frame boundaries.

Parameters:
- LINECNT_W, 10, width of the line counter; saturates at all-ones.
- PAL_LINE_TH, 10'd290, lines per field at or above which vmode=1 (PAL).

Ports:
- VCLK  in  1  video clock; single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- nDSYNC  in  1  low marks the sync nibble cycle on the data bus.
- Sync_i  in  4  data bus bits [3:0]: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; only valid when nDSYNC=0.
- nDeBlur_i  in  1  user config; 1 = deblur off; quasi-static, asynchronous.
- n15bit_i  in  1  user config; 1 = full 21-bit colour; quasi-static, asynchronous.
- demuxparams_o  out  5  {data_cnt, vmode, ndo_deblur, n15bit_mode}.
- n64_480i_o  out  1  1 = interlaced source detected.
- field_o  out  1  current field id; only meaningful when n64_480i_o=1.

Behaviour:
- Reset: async on nRST low. Reset values: data_cnt=2'b00, vmode=0, ndo_deblur=1, n15bit_mode=1, n64_480i_o=0, field_o=0. Line counter=0. Stored sync nibble=4'hF.
- Config sync: nDeBlur_i and n15bit_i each pass through 2 flip-flops (reset value 1) before use.
- data_cnt:
  - On a VCLK edge with nDSYNC=0: data_cnt <= 2'b01.
  - Otherwise: data_cnt <= data_cnt+1, wrapping 11->00.
  - After a sync cycle, the R, G and B bytes therefore see 01, 10, 11. 00 appears only if nDSYNC is missing; the demux ignores it.
- Sync capture: on each nDSYNC=0 cycle, store Sync_i as sync_prev. Edge detection compares stored versus current nibble only on nDSYNC=0 cycles:
  - negedge nHSYNC = prev[1] & !cur[1]
  - negedge nVSYNC = prev[3] & !cur[3]
- Line counter:
  - Increments on negedge nHSYNC, saturating at 2^LINECNT_W-1.
  - On negedge nVSYNC: evaluate, then clear to 0. If the same cycle also carries negedge nHSYNC, the clear wins.
- vmode: on negedge nVSYNC, vmode <= (linecnt >= PAL_LINE_TH).
- 480i / field detection:
  - On negedge nVSYNC: field_o <= cur[1] (nHSYNC level), and last_field <= the old field_o.
  - n64_480i_o <= (cur[1] != field_o), i.e. alternating fields mean interlaced.
  - Two consecutive equal fields return n64_480i_o to 0.
- Frame-boundary config: on negedge nVSYNC:
  - n15bit_mode <= the synced n15bit value.
  - ndo_deblur <= synced nDeBlur | the n64_480i value being written that cycle. Deblur is forced off in 480i.
  - Between frame boundaries these bits are frozen.
- Output timing: demuxparams_o is fully registered, so there is no combinational path from inputs. Updated vmode/config bits take effect on the cycle after the negedge nVSYNC sync cycle.
- Missing nVSYNC: the line counter saturates, and vmode/480i hold their last values.
- Reset mid-frame: all state returns to reset values immediately. The first negedge nVSYNC after reset is not detected unless the stored 4'hF sees a falling edge, which it does if Sync_i[3]=0.

Optional Feature:
- Macro: VINFO_HYST_EN.
- Defined:
  - vmode and n64_480i_o update only when the newly evaluated value has been identical at 2 consecutive negedge nVSYNC events. A 1-bit pending flag is kept per output.
  - ndo_deblur uses the hysteresis-filtered 480i value.
- Undefined: update on every negedge nVSYNC, as above.

Decomposition:
- Shared params header: sync nibble bit indices (VSYNC=3, CLAMP=2, HSYNC=1, CSYNC=0), demuxparams field positions, and reset defaults.
- Sub-module: n64_sync_edge. It holds the stored nibble and produces the negedge_hsync/negedge_vsync strobes; it is reusable by the OSD/scanline stages.

Test Plan:
- Reset, then one nDSYNC=0 cycle followed by 3 high cycles -> data_cnt 01, 10, 11, then the next nDSYNC gives 01. After reset, demuxparams_o=5'b00011.
- 263 nHSYNC falls per field, 3 fields -> vmode=0. Then 313 per field -> vmode=1 on the cycle after the next nVSYNC fall.
- nHSYNC level at nVSYNC fall alternating 0/1 -> n64_480i_o=1 and ndo_deblur=1 even with nDeBlur_i=0. Then two equal fields -> n64_480i_o=0, and ndo_deblur follows nDeBlur_i=0.
- Toggle n15bit_i mid-frame -> n15bit_mode unchanged until the next nVSYNC fall. Then it updates after the 2-FF delay plus boundary.
- Drop nVSYNC for 1100 lines -> line counter saturates at 1023 without wrap; vmode holds.
- Assert nRST mid-line -> all outputs at reset values asynchronously. With VINFO_HYST_EN, a single PAL field among NTSC fields leaves vmode=0.
